// File: rtl/alu_control_mdu_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide sequencer.
package alu_control_mdu_pkg;

  // ALU select codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // ALUOp codes from the main decoder
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MDU  = 7'b0000001;

  // RV32M funct3 codes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} mdu_state_e;

endpackage

// File: rtl/alu_control_mdu_iter_core.sv
// Iterative multiply/divide datapath: magnitude conversion, one bit per cycle
// shift-add or restoring division, iteration counter and final sign fix-up.
module alu_control_mdu_iter_core
  import alu_control_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic            special,
  output logic [XLEN-1:0] special_result,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic            is_div_q, hi_sel_q, rem_sel_q, quo_neg_q, rem_neg_q;

  logic            a_signed, b_signed, a_neg, b_neg, is_div;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN:0]   mul_sum, div_shift;
  logic            div_ge;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // Operand signedness, magnitudes and the special divide cases
  always_comb begin
    a_signed = (op != F3_MULHU) && (op != F3_DIVU) && (op != F3_REMU);
    b_signed = op inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    is_div   = op[2];
    div_zero = (b == '0);
    div_ovf  = !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = is_div & (div_zero | div_ovf);
    if (div_zero) special_result = op[1] ? a : '1;
    else          special_result = op[1] ? '0 : a;
  end

  // One iteration step; divide keeps remainder in hi and quotient shifts into lo
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    if (is_div_q) begin
      hi_n = div_ge ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up applied to the post-step values so the result is ready on the last step
  always_comb begin
    prod_fix = quo_neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    quo_fix  = quo_neg_q ? -lo_n : lo_n;
    rem_fix  = rem_neg_q ? -hi_n : hi_n;
    if (is_div_q) result = rem_sel_q ? rem_fix : quo_fix;
    else          result = hi_sel_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    last = (cnt_q == CntW'(1));
  end

  // Operand latch on start, then iterate while stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      hi_sel_q  <= 1'b0;
      rem_sel_q <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (start) begin
      cnt_q     <= CntW'(XLEN);
      hi_q      <= '0;
      lo_q      <= is_div ? a_mag : b_mag;
      opnd_q    <= is_div ? b_mag : a_mag;
      is_div_q  <= is_div;
      hi_sel_q  <= (op[1:0] != 2'b00);
      rem_sel_q <= op[1];
      quo_neg_q <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
    end else if (step) begin
      cnt_q <= cnt_q - CntW'(1);
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decoder with an iterative RV32M sequencer that stalls the core.
module alu_control_mdu
  import alu_control_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [3:0]      ALUcontrol_Out,
  output logic            is_mdu,
  output logic            stall,
  output logic [XLEN-1:0] mdu_result,
  output logic            mdu_done
);

  mdu_state_e      state_q, state_d;
  logic            start, step, res_load;
  logic [XLEN-1:0] res_value;
  logic            core_last, core_special;
  logic [XLEN-1:0] core_special_result, core_result;

  // Base ALU select decode
  always_comb begin
    ALUcontrol_Out = ALU_ADD;
    case (ALUOp)
      ALUOP_MEM: ALUcontrol_Out = ALU_ADD;
      ALUOP_BR:  ALUcontrol_Out = ALU_SUB;
      ALUOP_R: begin
        if (funct7 == FUNCT7_BASE) begin
          case (funct3)
            3'b000:  ALUcontrol_Out = ALU_ADD;
            3'b001:  ALUcontrol_Out = ALU_SLL;
            3'b010:  ALUcontrol_Out = ALU_SLT;
            3'b011:  ALUcontrol_Out = ALU_SLTU;
            3'b100:  ALUcontrol_Out = ALU_XOR;
            3'b101:  ALUcontrol_Out = ALU_SRL;
            3'b110:  ALUcontrol_Out = ALU_OR;
            default: ALUcontrol_Out = ALU_AND;
          endcase
        end else if (funct7 == FUNCT7_ALT) begin
          if (funct3 == 3'b000)      ALUcontrol_Out = ALU_SUB;
          else if (funct3 == 3'b101) ALUcontrol_Out = ALU_SRA;
        end
      end
      default: ALUcontrol_Out = ALU_ADD;
    endcase
  end

  assign is_mdu   = (ALUOp == ALUOP_R) && (funct7 == FUNCT7_MDU);
  assign stall    = valid_in & is_mdu & (state_q != StDone) & ~rst;
  assign mdu_done = (state_q == StDone);
  assign step     = (state_q == StMul) || (state_q == StDiv);

  // Sequencer next state; special divides skip straight to DONE
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    res_load  = 1'b0;
    res_value = core_result;
    unique case (state_q)
      StIdle: begin
        if (valid_in && is_mdu) begin
          if (core_special) begin
            state_d   = StDone;
            res_load  = 1'b1;
            res_value = core_special_result;
          end else begin
            start   = 1'b1;
            state_d = funct3[2] ? StDiv : StMul;
          end
        end
      end
      StMul, StDiv: begin
        if (core_last) begin
          state_d  = StDone;
          res_load = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset aborts any pending operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mdu_result <= '0;
    end else begin
      state_q <= state_d;
      if (res_load) mdu_result <= res_value;
    end
  end

  alu_control_mdu_iter_core #(
    .XLEN(XLEN)
  ) u_iter_core (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .step           (step),
    .op             (funct3),
    .a              (rs1_data),
    .b              (rs2_data),
    .last           (core_last),
    .special        (core_special),
    .special_result (core_special_result),
    .result         (core_result)
  );

endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench: decode table, directed RV32M cases, reset abort and random ops.
module tb_alu_control_mdu;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_in;
  logic [1:0]      ALUOp;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [3:0]      ALUcontrol_Out;
  logic            is_mdu, stall, mdu_done;
  logic [XLEN-1:0] mdu_result;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  alu_control_mdu #(
    .XLEN(XLEN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .ALUOp          (ALUOp),
    .funct7         (funct7),
    .funct3         (funct3),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .ALUcontrol_Out (ALUcontrol_Out),
    .is_mdu         (is_mdu),
    .stall          (stall),
    .mdu_result     (mdu_result),
    .mdu_done       (mdu_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference RV32M behaviour from wide native arithmetic
  function automatic logic [31:0] mdu_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    int ia = a;
    int ib = b;
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic dec_case(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [3:0] exp_alu, input logic exp_mdu);
    ALUOp    = op;
    funct7   = f7;
    funct3   = f3;
    valid_in = !exp_mdu;
    @(negedge clk);
    check_eq($sformatf("alu_sel_%b_%b_%b", op, f7, f3), 32'(ALUcontrol_Out), 32'(exp_alu));
    check_eq("is_mdu", 32'(is_mdu), 32'(exp_mdu));
    check_eq("base_stall", 32'(stall), 32'(0));
  endtask

  // Called just after a posedge with the DUT idle; returns just after the posedge leaving DONE
  task automatic run_mdu(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit perturb);
    int cyc = 0;
    int stall_cnt = 0;
    bit seen = 0;
    int exp_lat;
    logic [31:0] exp;
    bit spec = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    exp_lat  = spec ? 1 : XLEN + 1;
    valid_in = 1'b1;
    ALUOp    = 2'b10;
    funct7   = 7'b0000001;
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    exp_q.push_back(mdu_model(f3, a, b));
    while (!seen && cyc <= 2 * XLEN + 8) begin
      @(negedge clk);
      if (mdu_done) begin
        seen = 1;
        check_eq({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        check_eq({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        check_eq({name, "_stall_in_done"}, 32'(stall), 32'(0));
        check_eq({name, "_sb_empty"}, 32'(exp_q.size() == 0), 32'(0));
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check_eq({name, "_result"}, mdu_result, exp);
          last_res = exp;
        end
      end else if (stall) begin
        stall_cnt++;
      end
      if (perturb && cyc == 5) begin
        rs1_data = $urandom;
        rs2_data = $urandom;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({name, "_done_seen"}, 32'(seen), 32'(1));
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    // Reset, with an MDU op presented so the reset term of stall is exercised
    rst = 1'b1; valid_in = 1'b1; ALUOp = 2'b10; funct7 = 7'b0000001; funct3 = 3'b000;
    rs1_data = '0; rs2_data = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_stall", 32'(stall), 32'(0));
    check_eq("rst_done", 32'(mdu_done), 32'(0));
    check_eq("rst_result", mdu_result, 32'(0));
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Base decode table
    dec_case(2'b00, 7'b0100000, 3'b111, 4'b0000, 1'b0);
    dec_case(2'b01, 7'b0000000, 3'b000, 4'b0001, 1'b0);
    dec_case(2'b10, 7'b0000000, 3'b000, 4'b0000, 1'b0);
    dec_case(2'b10, 7'b0000000, 3'b111, 4'b0010, 1'b0);
    dec_case(2'b10, 7'b0000000, 3'b110, 4'b0011, 1'b0);
    dec_case(2'b10, 7'b0000000, 3'b100, 4'b0100, 1'b0);
    dec_case(2'b10, 7'b0000000, 3'b001, 4'b0101, 1'b0);
    dec_case(2'b10, 7'b0000000, 3'b101, 4'b0110, 1'b0);
    dec_case(2'b10, 7'b0000000, 3'b010, 4'b1000, 1'b0);
    dec_case(2'b10, 7'b0000000, 3'b011, 4'b1001, 1'b0);
    dec_case(2'b10, 7'b0100000, 3'b000, 4'b0001, 1'b0);
    dec_case(2'b10, 7'b0100000, 3'b101, 4'b0111, 1'b0);
    dec_case(2'b10, 7'b0100000, 3'b001, 4'b0000, 1'b0);
    dec_case(2'b10, 7'b0000001, 3'b101, 4'b0000, 1'b1);
    dec_case(2'b11, 7'b0000000, 3'b000, 4'b0000, 1'b0);
    valid_in = 1'b0;
    @(posedge clk); #1;

    // Directed RV32M cases, issued back to back
    run_mdu("mul_neg", 3'd0, 32'hFFFF_FFFF, 32'd7, 1'b0);
    run_mdu("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_mdu("mulh",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_mdu("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_mdu("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_mdu("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_mdu("divu_z",  3'd5, 32'd5, 32'd0, 1'b0);
    run_mdu("remu_z",  3'd7, 32'd5, 32'd0, 1'b0);
    run_mdu("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_mdu("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_mdu("mul_b2b", 3'd0, 32'h1234_5678, 32'h0000_0100, 1'b0);
    run_mdu("div_b2b", 3'd4, 32'd100, 32'hFFFF_FFFD, 1'b0);

    // Result holds after DONE while idle
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("hold_result", mdu_result, last_res);
    check_eq("hold_done", 32'(mdu_done), 32'(0));
    @(posedge clk); #1;

    // Reset at iteration 10 of a DIV
    valid_in = 1'b1; ALUOp = 2'b10; funct7 = 7'b0000001; funct3 = 3'd4;
    rs1_data = 32'd1000; rs2_data = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_stall_in_rst", 32'(stall), 32'(0));
    check_eq("abort_no_done_pre", 32'(mdu_done), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
    check_eq("abort_no_done", 32'(mdu_done), 32'(0));
    check_eq("abort_result", mdu_result, 32'(0));
    @(posedge clk); #1;
    run_mdu("after_abort", 3'd4, 32'd1000, 32'd7, 1'b0);

    // Random operations, occasionally with a zero or small divisor
    for (int i = 0; i < 10; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      run_mdu($sformatf("rand%0d", i), rf3, ra, rb, 1'b0);
    end
    valid_in = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_control_mdu.md
# alu_control_mdu

Parametrised successor to the single-cycle ALU control decoder. It decodes {ALUOp, funct7, funct3} to the 4-bit ALU select for base RV32I ops and adds RV32M support through an iterative multiply/divide sequencer. The sequencer stalls the single-cycle core until the result is ready. It sits between the main decoder/register file and the writeback mux, alongside the ALU.

## Interface
- XLEN, 32, operand/result width; even, ≥ 8
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  instruction in decode is valid
- ALUOp  in  2  from main control: 00 load/store, 01 branch, 10 R-type
- funct7  in  7  instruction funct7
- funct3  in  3  instruction funct3
- rs1_data  in  XLEN  operand A
- rs2_data  in  XLEN  operand B
- ALUcontrol_Out  out  4  ALU select, combinational
- is_mdu  out  1  ALUOp=10 and funct7=0000001, combinational
- stall  out  1  freeze PC/regfile write while MDU op is pending
- mdu_result  out  XLEN  registered MDU result
- mdu_done  out  1  one-cycle pulse; mdu_result valid, writeback enable

## Operation
- ALU encodings:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100
  - SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001
- Decode rules:
  - ALUOp=00 gives ADD for any funct3.
  - ALUOp=01 gives SUB.
  - ALUOp=10: funct7 0000000 with funct3 000/111/110/100/001/101/010/011 gives ADD/AND/OR/XOR/SLL/SRL/SLT/SLTU.
  - ALUOp=10: funct7 0100000 with funct3 000 gives SUB; with 101 gives SRA.
  - All other combinations, including MDU ops, give 0000.
- MDU funct3 codes:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Signedness:
  - Operands are converted to magnitudes, then iterated unsigned.
  - Final negate if signs differ (MUL/DIV); REM takes the sign of the dividend.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
- MUL returns the low XLEN bits of the 2·XLEN product. MULH/MULHSU/MULHU return the high XLEN bits.
- Divide special cases, detected in IDLE and skipping iteration:
  - Divide by zero: quotient all-ones, remainder = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = −1): quotient = rs1, remainder = 0.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL or IDLE→DIV when valid_in & is_mdu; operands latched.
  - IDLE→DONE directly for special cases.
  - MUL/DIV iterate XLEN cycles (shift-add / restoring, one bit per cycle) via a down-counter, then go to DONE.
  - DONE→IDLE unconditionally.
- stall = valid_in & is_mdu & (state≠DONE) & !rst.
- The core holds the instruction and operands stable while stall is high. Operand changes mid-op are ignored; latched values are used.

## Timing
- Cycle 0: accept (IDLE); stall=1.
- Cycles 1..XLEN: iterate; stall=1.
- Cycle XLEN+1: DONE; mdu_done=1, stall=0, result written back, PC advances.
- Total MDU latency is XLEN+2 cycles; special cases take 2 cycles.
- Base ops have 0-cycle latency; stall stays 0.
- Reset values: state IDLE, mdu_result 0, mdu_done 0, counter 0, stall 0.
- Reset mid-operation:
  - Aborts in the same edge; no mdu_done pulse.
  - The next cycle re-accepts if valid_in & is_mdu.
- mdu_result holds its value after DONE until the next DONE.
- In DONE, is_mdu for a new instruction is not accepted until IDLE. Back-to-back MDU ops therefore incur no lost or duplicated start.

## Structure
- Shared package/header holds:
  - ALU select localparams (4-bit codes above)
  - ALUOp codes
  - MDU funct3 codes and FUNCT7_MDU
  - FSM state encoding
- Sub-module mdu_iter_core holds the magnitude conversion, shift-add/restoring datapath, counter and sign fix-up.
- The top holds the decode, FSM and stall logic.

## Test plan
- ALUOp=10, funct7=0100000, funct3=101 → ALUcontrol_Out=0111, stall=0. funct3=011 with funct7=0 → 1001.
- MUL rs1=0xFFFFFFFF (−1), rs2=7 → mdu_result=0xFFFFFFF9. mdu_done is pulsed exactly 33 cycles after accept; stall high for 33 cycles.
- MULHU with 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU with the same operands → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each done at cycle 1. DIV 0x80000000/−1 → 0x80000000.
- rst pulsed at iteration 10 of a DIV → no mdu_done, state IDLE, mdu_result=0. Back-to-back MUL then DIV → two done pulses with correct results.
